// File: rtl/ppi_bus_master.sv
// ppi_bus_master: CPU-side initiator producing timed 8255 PPI read/write cycles plus the post-reset PPI Reset pulse.
// Latency: done SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after acceptance, 1 cycle for a rejected control read.
// Backpressure: busy high from acceptance until done and during PPI reset; req while busy is dropped, not queued.
module ppi_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RST_CYC    = 4
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       req,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic [5:0] control,
    inout  wire  [7:0] D
);

    typedef enum logic [2:0] {
        S_PPI_RST,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC);
    localparam logic [7:0] RST_LD    = 8'(RST_CYC);

    state_t     state;
    logic [7:0] cnt;
    logic       lat_rw;
    logic [7:0] lat_wdata;
    logic [7:0] hold_q;
    logic       ncs;
    logic       nre;
    logic       nwr;
    logic       ppi_rst;
    logic [1:0] a;
    logic       d_oe;

    assign control = {ncs, nre, nwr, ppi_rst, a};
    // lat_wdata only changes on acceptance in IDLE, when d_oe is already low
    assign D       = d_oe ? lat_wdata : 8'hzz;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state     <= S_PPI_RST;
            cnt       <= RST_LD;
            lat_rw    <= 1'b0;
            lat_wdata <= 8'h00;
            hold_q    <= 8'h00;
            ncs       <= 1'b1;
            nre       <= 1'b1;
            nwr       <= 1'b1;
            ppi_rst   <= 1'b1;
            a         <= 2'b00;
            d_oe      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_PPI_RST: begin
                    if (cnt == 8'd1) begin
                        ppi_rst <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        lat_rw    <= rw;
                        lat_wdata <= wdata;
                        busy      <= 1'b1;
                        // control-word readback is not supported by the PPI
                        if (rw && addr == 2'b11) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            cnt   <= SETUP_LD;
                            ncs   <= 1'b0;
                            a     <= addr;
                            d_oe  <= !rw;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'd1) begin
                        state <= S_STROBE;
                        cnt   <= STROBE_LD;
                        nre   <= !lat_rw;
                        nwr   <= lat_rw;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == 8'd1) begin
                        if (lat_rw) begin
                            hold_q <= D;
                        end
                        nre   <= 1'b1;
                        nwr   <= 1'b1;
                        state <= S_HOLD;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 8'd1) begin
                        ncs   <= 1'b1;
                        d_oe  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                        if (lat_rw) begin
                            rdata <= hold_q;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
